seq_shift_add_multiplier: RTL and testbench

//  - Parametrised iterative radix-2 shift-add multiplier; one multiplier bit per clock.
//  - Trades the fully combinational 4x4 array for WIDTH-cycle latency and much less area.
//  - Valid/ready handshakes on both sides; result held until the consumer accepts it.
//  - Sits between operand producers and result consumers in datapaths too wide for an array multiplier.

---
 rtl/seq_shift_add_multiplier.sv | 117 +++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier.sv
// Iterative radix-2 shift-add multiplier with valid/ready handshakes; one multiplier bit per clock.
// Define MULT_SIGNED_EN to add the in_signed port (sign-magnitude two's-complement multiply).
module seq_shift_add_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MULT_SIGNED_EN
    input  logic               in_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] acc_q, out_q;
    logic [CW-1:0]      cnt_q;

    logic [WIDTH-1:0]   a_in, b_in;
    logic               bit_set;
    logic [2*WIDTH-1:0] addend, acc_sum, prod_final;

`ifdef MULT_SIGNED_EN
    logic neg_q, neg_in;

    // Negative operands are stored as magnitudes; -2^(W-1) still fits unsigned.
    always_comb begin
        a_in   = (in_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_in   = (in_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
        neg_in = in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
    end
`else
    always_comb begin
        a_in = a;
        b_in = b;
    end
`endif

    always_comb begin
        bit_set = |(b_q & (WIDTH'(1) << cnt_q));
        addend  = bit_set ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
        acc_sum = acc_q + addend;
`ifdef MULT_SIGNED_EN
        prod_final = neg_q ? (~acc_sum + 1'b1) : acc_sum;
`else
        prod_final = acc_sum;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (in_valid) state_d = StRun;
            StRun:  if (cnt_q == LAST) state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            out_q <= '0;
`ifdef MULT_SIGNED_EN
            neg_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q   <= a_in;
                        b_q   <= b_in;
                        acc_q <= '0;
                        cnt_q <= '0;
`ifdef MULT_SIGNED_EN
                        neg_q <= neg_in;
`endif
                    end
                end
                StRun: begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) out_q <= prod_final;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out       = out_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: WIDTH=4 vector table and corner sequences,
// WIDTH=8 boundary case and random sweep against a plain a*b model.
module tb_seq_shift_add_multiplier;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       iv4, ir4, ov4, or4;
    logic [3:0] a4, b4;
    logic [7:0] o4;
`ifdef MULT_SIGNED_EN
    logic       sg4;
`endif

    logic        iv8, ir8, ov8, or8;
    logic [7:0]  a8, b8;
    logic [15:0] o8;

    seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
`ifdef MULT_SIGNED_EN
        .in_signed(sg4),
`endif
        .out_valid(ov4), .out_ready(or4), .out(o4)
    );

    seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
`ifdef MULT_SIGNED_EN
        .in_signed(1'b0),
`endif
        .out_valid(ov8), .out_ready(or8), .out(o8)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        bit         sgn;
        int         stall;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mul4(input logic [3:0] a, input logic [3:0] b, input bit sgn,
                        input int stall, input logic [7:0] exp, input string tag);
        int lat;
        @(negedge clk);
        check({tag, " in_ready"}, 64'(ir4), 64'd1);
        iv4 = 1'b1; a4 = a; b4 = b; or4 = 1'b0;
`ifdef MULT_SIGNED_EN
        sg4 = sgn;
`endif
        @(posedge clk);
        #1 iv4 = 1'b0; a4 = '0; b4 = '0;
        lat = 0;
        while (!ov4 && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd4);
        check({tag, " out"}, 64'(o4), 64'(exp));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            iv4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
            @(posedge clk);
            #1 check({tag, " hold"}, 64'({ov4, ir4, o4}), 64'({1'b1, 1'b0, exp}));
        end
        @(negedge clk);
        iv4 = 1'b0; or4 = 1'b1;
        @(posedge clk);
        #1 check({tag, " release"}, 64'({ov4, ir4, o4}), 64'({1'b0, 1'b1, exp}));
        or4 = 1'b0;
    endtask

    task automatic mul8(input logic [7:0] a, input logic [7:0] b, input int stall,
                        input logic [15:0] exp, input string tag);
        int lat;
        @(negedge clk);
        iv8 = 1'b1; a8 = a; b8 = b; or8 = 1'b0;
        @(posedge clk);
        #1 iv8 = 1'b0; a8 = $urandom; b8 = $urandom;
        lat = 0;
        while (!ov8 && lat < 30) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd8);
        check({tag, " out"}, 64'(o8), 64'(exp));
        repeat (stall) @(posedge clk);
        #1 check({tag, " hold"}, 64'({ov8, o8}), 64'({1'b1, exp}));
        @(negedge clk);
        or8 = 1'b1;
        @(posedge clk);
        #1 check({tag, " release"}, 64'({ov8, ir8}), 64'({1'b0, 1'b1}));
        or8 = 1'b0;
    endtask

    initial begin
        vec_t        vecs[$];
        int          acc_cyc[$];
        logic [7:0]  outs[$];
        logic [7:0]  ra, rb;
        int          rstall;

        vecs.push_back('{4'd15, 4'd15, 1'b0, 0,  8'd225});
        vecs.push_back('{4'd0,  4'd9,  1'b0, 0,  8'd0});
        vecs.push_back('{4'd13, 4'd11, 1'b0, 2,  8'd143});
        vecs.push_back('{4'd1,  4'd8,  1'b0, 0,  8'd8});
        vecs.push_back('{4'd6,  4'd7,  1'b0, 10, 8'd42});
`ifdef MULT_SIGNED_EN
        vecs.push_back('{4'h8,  4'h7,  1'b1, 0,  8'hC8});
        vecs.push_back('{4'h8,  4'h8,  1'b1, 0,  8'h40});
        vecs.push_back('{4'hF,  4'hF,  1'b0, 0,  8'd225});
        vecs.push_back('{4'h6,  4'h7,  1'b1, 0,  8'd42});
        sg4 = 1'b0;
`endif

        rst = 1'b1;
        iv4 = 1'b0; a4 = '0; b4 = '0; or4 = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset w4", 64'({ir4, ov4, o4}), 64'({1'b1, 1'b0, 8'd0}));
        check("reset w8", 64'({ir8, ov8, o8}), 64'({1'b1, 1'b0, 16'd0}));

        foreach (vecs[i])
            mul4(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].stall, vecs[i].exp,
                 $sformatf("vec%0d", i));

        // Last product must persist in IDLE.
        repeat (3) @(posedge clk);
        #1 check("idle keeps out", 64'({ir4, o4}), 64'({1'b1, vecs[vecs.size()-1].exp}));

        // Back-to-back accepts with in_valid held high and out_ready held at 1.
        @(negedge clk);
        iv4 = 1'b1; a4 = 4'd0; b4 = 4'd9; or4 = 1'b1;
        for (int c = 0; c < 40 && (acc_cyc.size() < 2 || outs.size() < 2); c++) begin
            if (c > 0) @(negedge clk);
            if (acc_cyc.size() == 1) begin
                a4 = 4'd9; b4 = 4'd0;
            end
            if (ir4) acc_cyc.push_back(c);
            if (ov4) outs.push_back(o4);
            @(posedge clk);
        end
        @(negedge clk);
        iv4 = 1'b0; or4 = 1'b0;
        check("b2b accepts", 64'(acc_cyc.size()), 64'd2);
        check("b2b outputs", 64'(outs.size()), 64'd2);
        if (acc_cyc.size() == 2) check("b2b spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd6);
        if (outs.size() == 2) check("b2b products", 64'({outs[0], outs[1]}), 64'd0);

        // Reset in the middle of RUN discards the product.
        mul4(4'd7, 4'd3, 1'b0, 0, 8'd21, "pre-rst");
        @(negedge clk);
        iv4 = 1'b1; a4 = 4'd13; b4 = 4'd11;
        @(posedge clk);
        #1 iv4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrun reset", 64'({ir4, ov4, o4}), 64'({1'b1, 1'b0, 8'd0}));
        repeat (6) @(posedge clk);
        #1 check("no stale result", 64'({ir4, ov4, o4}), 64'({1'b1, 1'b0, 8'd0}));
        mul4(4'd3, 4'd5, 1'b0, 0, 8'd15, "post-rst");

        mul8(8'd255, 8'd255, 0, 16'hFE01, "w8 max");
        mul8(8'd0, 8'd0, 1, 16'h0000, "w8 zero");

        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rstall = $urandom_range(0, 3);
            mul8(ra, rb, rstall, 16'(int'(ra) * int'(rb)), $sformatf("rnd%0d %0d*%0d", n, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
